irq_ctrl_prio: RTL and testbench
================================

Name: irq_ctrl_prio

Overview:
- Parametrised interrupt controller between external interrupt lines and the miriscv core trap logic.
- Replaces the fixed 32-line request/finish scheme with configurable channel count, input synchronisers, per-channel edge/level mode, pending latches and fixed priority.
- Runs a request -> acknowledge -> return handshake with the core; pulses a per-channel finish line when the handler returns.

Parameters:
- N_SRC, 32, number of interrupt channels (2..32).
- ID_W, $clog2(N_SRC), width of the channel index.
- SYNC_STAGES, 2, flip-flop synchroniser depth on int_req_i (0 = already synchronous).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- int_req_i  in  N_SRC  raw interrupt request lines.
- int_edge_i  in  N_SRC  per-channel mode, 1 = rising-edge, 0 = level; static in normal use.
- mie_i  in  N_SRC  per-channel enable mask from CSR.
- irq_o  out  1  interrupt request to core.
- irq_id_o  out  ID_W  index of the requested channel; valid while irq_o = 1 and through SERVICE.
- irq_ack_i  in  1  core entered trap for irq_id_o (1-cycle pulse).
- mret_i  in  1  core executed mret (1-cycle pulse).
- int_fin_o  out  N_SRC  one-hot, 1-cycle finish pulse to the serviced source.

Behaviour:
- Reset: all sync flops, prev_req, pending and state cleared; irq_o = 0, irq_id_o = 0, int_fin_o = 0; FSM = IDLE. Reset mid-service drops everything; int_fin_o is not issued.
- Synchroniser: s_req = int_req_i delayed by SYNC_STAGES flops.
- Edge channel: pending[i] is set when s_req[i] & ~prev_req[i]. It is cleared on irq_ack_i for i = irq_id_o. If set and clear occur in the same cycle, set wins.
- Level channel: pending[i] = s_req[i], combinational.
- Candidate vector: pending & mie_i. Lowest index wins (fixed priority).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if any candidate exists, register its index into irq_id_o, raise irq_o and go to REQ.
  - REQ: irq_o = 1 and irq_id_o frozen. A higher-priority arrival does not preempt.
  - REQ -> SERVICE on irq_ack_i; irq_o drops at that edge.
  - REQ -> IDLE with irq_o dropped if mie_i[irq_id_o] = 0, or for level channels if s_req[irq_id_o] = 0 (request withdrawn). Re-arbitration happens in IDLE on the next cycle.
  - SERVICE: irq_o = 0 and no nesting.
  - SERVICE -> IDLE on mret_i. int_fin_o[irq_id_o] = 1 for exactly the following cycle.
  - IDLE cannot re-assert irq_o in the cycle int_fin_o is high. This gives the source one cycle to drop a level request.
- Latency with SYNC_STAGES = 0: request sampled high at edge k sets pending at edge k; irq_o is high after edge k+1. Each synchroniser stage adds one cycle.
- irq_ack_i outside REQ and mret_i outside SERVICE are ignored.
- If irq_ack_i and a withdraw condition are both true in REQ, irq_ack_i wins and the FSM goes to SERVICE.
- Unused upper ID values (N_SRC not a power of 2) are never produced.

Decomposition:
- Shared package irq_pkg:
  - state enum irq_state_e {IDLE, REQ, SERVICE};
  - localparam defaults for N_SRC and SYNC_STAGES;
  - function prio_enc(vector) -> {valid, index}.
- One sub-module, irq_sync_edge: per-channel synchroniser plus edge detector, instantiated with a generate loop or as a vector.
- FSM, pending latches and arbiter stay in irq_ctrl_prio.

Test Plan:
- Edge channel 5, mie = all 1, SYNC_STAGES = 2: pulse int_req_i[5] for 1 cycle -> irq_o high 4 edges later with irq_id_o = 5. Ack -> irq_o low, pending[5] = 0. mret -> int_fin_o = 32'h20 for one cycle.
- Priority: channels 4 and 15 (edge) rise in the same cycle -> irq_id_o = 4 first. After its mret plus one idle cycle -> irq_id_o = 15.
- No preemption: channel 15 in REQ, channel 0 then rises -> irq_id_o stays 15 until ack. After mret, channel 0 is served.
- Level channel 0 held high through its mret, then dropped the cycle int_fin_o[0] = 1 -> no second irq_o. Held high for 3 more cycles instead -> irq_o re-asserts with id 0.
- Mask withdraw: channel 3 in REQ, mie_i[3] cleared -> irq_o = 0 next edge and FSM = IDLE. Re-enabling mie_i[3] -> re-request with id 3, since the edge pending bit was retained.
- Reset mid-SERVICE: assert rst_n = 0 asynchronously -> irq_o = 0, int_fin_o = 0 and pending = 0 immediately. A later mret_i produces no int_fin_o.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
package irq_pkg;

  localparam int unsigned N_SRC_DEF       = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned MAX_SRC         = 32;
  localparam int unsigned MAX_ID_W        = 5;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } prio_t;

  // Fixed priority: lowest set index wins.
  function automatic prio_t prio_enc(input logic [MAX_SRC-1:0] vec);
    prio_t res;
    res = '0;
    for (int i = int'(MAX_SRC) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.valid = 1'b1;
        res.idx   = MAX_ID_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-channel input synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] s_req_c,
  output logic [N-1:0] rise_c
);

  logic [N-1:0] prev_q;

  generate
    if (STAGES == 0) begin : g_nosync
      assign s_req_c = req;
    end else begin : g_sync
      logic [N-1:0] chain_q [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(STAGES); i++) chain_q[i] <= '0;
        end else begin
          chain_q[0] <= req;
          for (int i = 1; i < int'(STAGES); i++) chain_q[i] <= chain_q[i-1];
        end
      end

      assign s_req_c = chain_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= s_req_c;
  end

  assign rise_c = s_req_c & ~prev_q;

endmodule

// File: rtl/irq_ctrl_prio.sv
// Interrupt controller: pending latches, fixed-priority arbiter and
// request/ack/mret handshake FSM towards the core.
module irq_ctrl_prio
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC       = N_SRC_DEF,
  parameter int unsigned ID_W        = $clog2(N_SRC),
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] int_edge_i,
  input  logic [N_SRC-1:0] mie_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  input  logic             mret_i,
  output logic [N_SRC-1:0] int_fin_o
);

  logic [N_SRC-1:0] s_req;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] fin_q;
  logic [N_SRC-1:0] fin_d;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  id_d;
  logic             irq_q;
  logic             irq_d;
  irq_state_e       state_q;
  irq_state_e       state_d;
  prio_t            prio;

  irq_sync_edge #(
    .N      (N_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (int_req_i),
    .s_req_c (s_req),
    .rise_c  (rise)
  );

  // Edge channels latch; level channels follow the synchronised line.
  assign pending = (int_edge_i & pend_q) | (~int_edge_i & s_req);
  assign cand    = pending & mie_i;
  assign prio    = prio_enc(MAX_SRC'(cand));
  assign pend_d  = (pend_q & ~clr) | (rise & int_edge_i);

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    fin_d   = '0;
    clr     = '0;
    case (state_q)
      IDLE: begin
        // Hold off one cycle after a finish so a level source can drop.
        if (fin_q == '0 && prio.valid) begin
          state_d = REQ;
          irq_d   = 1'b1;
          id_d    = ID_W'(prio.idx);
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = SERVICE;
          irq_d   = 1'b0;
          clr     = N_SRC'(1) << id_q;
        end else if (!mie_i[id_q] || (!int_edge_i[id_q] && !s_req[id_q])) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      SERVICE: begin
        if (mret_i) begin
          state_d = IDLE;
          fin_d   = N_SRC'(1) << id_q;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      fin_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      fin_q   <= fin_d;
      pend_q  <= pend_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_id_o  = id_q;
  assign int_fin_o = fin_q;

endmodule

// File: tb/tb_irq_ctrl_prio.sv
// Directed bench: a 32-channel controller with two sync stages and an
// 8-channel one without synchroniser for latency and level-mode cases.
module tb_irq_ctrl_prio;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] req, edge_m, mie, fin;
  logic        irq, ack, mret;
  logic [4:0]  id;

  logic [7:0]  req0, edge0, mie0, fin0;
  logic        irq0, ack0, mret0;
  logic [2:0]  id0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_ctrl_prio #(.N_SRC(32), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_req_i  (req),
    .int_edge_i (edge_m),
    .mie_i      (mie),
    .irq_o      (irq),
    .irq_id_o   (id),
    .irq_ack_i  (ack),
    .mret_i     (mret),
    .int_fin_o  (fin)
  );

  irq_ctrl_prio #(.N_SRC(8), .SYNC_STAGES(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_req_i  (req0),
    .int_edge_i (edge0),
    .mie_i      (mie0),
    .irq_o      (irq0),
    .irq_id_o   (id0),
    .irq_ack_i  (ack0),
    .mret_i     (mret0),
    .int_fin_o  (fin0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input int ch);
    req[ch] = 1'b1;
    tick();
    req[ch] = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;  edge_m = '1;  mie  = '1;  ack  = 1'b0; mret  = 1'b0;
    req0   = '0;  edge0  = 8'hFE; mie0 = '1; ack0 = 1'b0; mret0 = 1'b0;
    tick(3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_fin", fin, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Edge channel 5 through two sync stages
    pulse_req(5);
    check("ch5_lat1", 32'(irq), 32'd0);
    tick(2);
    check("ch5_lat3", 32'(irq), 32'd0);
    tick();
    check("ch5_irq", 32'(irq), 32'd1);
    check("ch5_id", 32'(id), 32'd5);
    tick(2);
    check("ch5_hold", 32'(irq), 32'd1);
    do_ack();
    check("ch5_ack_irq", 32'(irq), 32'd0);
    tick(2);
    check("ch5_service", 32'(irq), 32'd0);
    do_mret();
    check("ch5_fin", fin, 32'h20);
    tick();
    check("ch5_fin_off", fin, 32'h0);
    tick(3);
    check("ch5_no_repeat", 32'(irq), 32'd0);

    // Stray ack/mret outside their states
    do_ack();
    do_mret();
    check("stray_fin", fin, 32'h0);
    check("stray_irq", 32'(irq), 32'd0);

    // Simultaneous channels 4 and 15
    req[4] = 1'b1; req[15] = 1'b1;
    tick();
    req = '0;
    tick(3);
    check("prio_irq", 32'(irq), 32'd1);
    check("prio_id4", 32'(id), 32'd4);
    do_ack();
    do_mret();
    check("prio_fin4", fin, 32'h10);
    check("prio_gap0", 32'(irq), 32'd0);
    tick();
    check("prio_gap1", 32'(irq), 32'd0);
    tick();
    check("prio_irq15", 32'(irq), 32'd1);
    check("prio_id15", 32'(id), 32'd15);
    do_ack();
    do_mret();
    check("prio_fin15", fin, 32'h8000);
    tick(3);

    // No preemption of channel 15 by channel 0
    pulse_req(15);
    tick(3);
    check("np_id15", 32'(id), 32'd15);
    pulse_req(0);
    tick(4);
    check("np_hold_irq", 32'(irq), 32'd1);
    check("np_hold_id", 32'(id), 32'd15);
    do_ack();
    do_mret();
    check("np_fin15", fin, 32'h8000);
    tick(2);
    check("np_irq0", 32'(irq), 32'd1);
    check("np_id0", 32'(id), 32'd0);
    do_ack();
    do_mret();
    check("np_fin0", fin, 32'h1);
    tick(3);

    // Mask withdraw keeps edge pending
    pulse_req(3);
    tick(3);
    check("mw_irq", 32'(irq), 32'd1);
    check("mw_id", 32'(id), 32'd3);
    mie[3] = 1'b0;
    tick();
    check("mw_drop", 32'(irq), 32'd0);
    tick(3);
    check("mw_idle", 32'(irq), 32'd0);
    mie[3] = 1'b1;
    tick();
    check("mw_rereq", 32'(irq), 32'd1);
    check("mw_reid", 32'(id), 32'd3);
    do_ack();
    do_mret();
    check("mw_fin", fin, 32'h8);
    tick(3);

    // Zero-stage latency on the small instance
    req0[2] = 1'b1;
    tick();
    req0[2] = 1'b0;
    check("z_lat0", 32'(irq0), 32'd0);
    tick();
    check("z_irq", 32'(irq0), 32'd1);
    check("z_id", 32'(id0), 32'd2);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    mret0 = 1'b1; tick(); mret0 = 1'b0;
    check("z_fin", 32'(fin0), 32'h4);
    tick(2);

    // Level channel 0 dropped in the finish cycle
    req0[0] = 1'b1;
    tick();
    check("lv_irq", 32'(irq0), 32'd1);
    check("lv_id", 32'(id0), 32'd0);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    mret0 = 1'b1; tick(); mret0 = 1'b0;
    check("lv_fin", 32'(fin0), 32'h1);
    req0[0] = 1'b0;
    tick();
    check("lv_drop1", 32'(irq0), 32'd0);
    tick(2);
    check("lv_drop3", 32'(irq0), 32'd0);

    // Level channel 0 held after finish re-requests
    req0[0] = 1'b1;
    tick();
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    mret0 = 1'b1; tick(); mret0 = 1'b0;
    check("lh_fin", 32'(fin0), 32'h1);
    tick();
    check("lh_gap", 32'(irq0), 32'd0);
    tick();
    check("lh_rereq", 32'(irq0), 32'd1);
    check("lh_id", 32'(id0), 32'd0);
    req0[0] = 1'b0;
    tick();
    check("lh_withdraw", 32'(irq0), 32'd0);
    tick(2);

    // Asynchronous reset during SERVICE
    pulse_req(7);
    tick(3);
    check("rs_irq", 32'(irq), 32'd1);
    do_ack();
    pulse_req(9);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("rs_async_irq", 32'(irq), 32'd0);
    check("rs_async_fin", fin, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick();
    do_mret();
    check("rs_no_fin", fin, 32'h0);
    tick(4);
    check("rs_no_pending", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
